// File: rtl/frame_scan_controller.sv
// Raster scan sequencer: walks x/y over the screen, aligns the
// renderer colour with its coordinate and strobes the VGA plot port.
//
// Ports:
//   clk, resetn           pixel clock, synchronous active-low reset
//   start                 frame request pulse (one pending request kept)
//   gameState             game state, latched at frame acceptance
//   colRunning..colOver   colours from the four state renderers
//   x, y                  scan coordinate to the renderers
//   plotX, plotY          coordinate of the pixel being written
//   plotColor             colour for plotX/plotY (0 when not plotting)
//   plot                  write strobe, one pixel per high cycle
//   frameClk              one-cycle pulse when a frame completes
//   busy                  high from frame acceptance until DONE exits
module frame_scan_controller #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int PIPE_LAT = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] gameState,
    input  logic [2:0] colRunning,
    input  logic [2:0] colMenu,
    input  logic [2:0] colPause,
    input  logic [2:0] colOver,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic [7:0] plotX,
    output logic [7:0] plotY,
    output logic [2:0] plotColor,
    output logic       plot,
    output logic       frameClk,
    output logic       busy
);

    localparam logic [1:0] GAME_MENU    = 2'd0;
    localparam logic [1:0] GAME_RUNNING = 2'd1;
    localparam logic [1:0] GAME_PAUSE   = 2'd2;
    localparam logic [1:0] GAME_OVER    = 2'd3;

    localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
    localparam logic [7:0] Y_LAST = 8'(SCREEN_H - 1);
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    state_t        state;
    state_t        stateNext;
    logic [7:0]    xNext;
    logic [7:0]    yNext;
    logic          pending;
    logic          pendingNext;
    logic [1:0]    stateLatched;
    logic [1:0]    latchNext;
    logic [DW-1:0] drainCnt;
    logic [DW-1:0] drainNext;
    logic          scanValid;

    logic          dlValid [PIPE_LAT];
    logic [7:0]    dlX     [PIPE_LAT];
    logic [7:0]    dlY     [PIPE_LAT];
    logic [2:0]    colSel;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            x            <= '0;
            y            <= '0;
            pending      <= 1'b0;
            stateLatched <= GAME_MENU;
            drainCnt     <= '0;
        end else begin
            state        <= stateNext;
            x            <= xNext;
            y            <= yNext;
            pending      <= pendingNext;
            stateLatched <= latchNext;
            drainCnt     <= drainNext;
        end
    end

    always_comb begin
        stateNext   = state;
        xNext       = x;
        yNext       = y;
        pendingNext = pending;
        latchNext   = stateLatched;
        drainNext   = drainCnt;
        scanValid   = 1'b0;
        frameClk    = 1'b0;
        busy        = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    latchNext = gameState;
                    xNext     = '0;
                    yNext     = '0;
                    stateNext = SCAN;
                end
            end
            SCAN: begin
                scanValid   = 1'b1;
                pendingNext = pending | start;
                if (x == X_LAST) begin
                    if (y == Y_LAST) begin
                        // Hold the last coordinate while the pipe drains.
                        drainNext = '0;
                        stateNext = DRAIN;
                    end else begin
                        xNext = '0;
                        yNext = y + 8'd1;
                    end
                end else begin
                    xNext = x + 8'd1;
                end
            end
            DRAIN: begin
                pendingNext = pending | start;
                if (drainCnt == DRAIN_LAST) begin
                    stateNext = DONE;
                end else begin
                    drainNext = drainCnt + 1'b1;
                end
            end
            DONE: begin
                frameClk    = 1'b1;
                pendingNext = 1'b0;
                // A start seen here counts as pending and is consumed now.
                if (pending || start) begin
                    latchNext = gameState;
                    xNext     = '0;
                    yNext     = '0;
                    stateNext = SCAN;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Delay line so plotX/plotY line up with the renderer colour.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                dlValid[i] <= 1'b0;
                dlX[i]     <= '0;
                dlY[i]     <= '0;
            end
        end else begin
            dlValid[0] <= scanValid;
            dlX[0]     <= x;
            dlY[0]     <= y;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dlValid[i] <= dlValid[i-1];
                dlX[i]     <= dlX[i-1];
                dlY[i]     <= dlY[i-1];
            end
        end
    end

    always_comb begin
        colSel = '0;
        unique case (stateLatched)
            GAME_RUNNING: colSel = colRunning;
            GAME_MENU:    colSel = colMenu;
            GAME_PAUSE:   colSel = colPause;
            GAME_OVER:    colSel = colOver;
            default:      colSel = '0;
        endcase
    end

    assign plot      = dlValid[PIPE_LAT-1];
    assign plotX     = dlX[PIPE_LAT-1];
    assign plotY     = dlY[PIPE_LAT-1];
    assign plotColor = plot ? colSel : 3'd0;

endmodule

// File: tb/tb_frame_scan_controller.sv
// Randomized scoreboard bench for frame_scan_controller: a frame-level
// reference model predicts every pixel, frame pulse and busy level.
module tb_frame_scan_controller;

    localparam int W   = 160;
    localparam int H   = 120;
    localparam int LAT = 2;
    localparam int NPIX = W * H;
    localparam int DONEJ = NPIX + LAT + 1;

    localparam logic [1:0] GAME_MENU    = 2'd0;
    localparam logic [1:0] GAME_RUNNING = 2'd1;
    localparam logic [1:0] GAME_PAUSE   = 2'd2;
    localparam logic [1:0] GAME_OVER    = 2'd3;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [1:0] gameState;
    logic [2:0] colRunning, colMenu, colPause, colOver;
    logic [7:0] x, y, plotX, plotY;
    logic [2:0] plotColor;
    logic       plot, frameClk, busy;

    frame_scan_controller dut (
        .clk(clk), .resetn(resetn), .start(start),
        .gameState(gameState),
        .colRunning(colRunning), .colMenu(colMenu),
        .colPause(colPause), .colOver(colOver),
        .x(x), .y(y), .plotX(plotX), .plotY(plotY),
        .plotColor(plotColor), .plot(plot),
        .frameClk(frameClk), .busy(busy)
    );

    always #5 clk = ~clk;

    // Renderers: two-cycle latency from x/y to colour.
    logic [7:0] xd1, xd2, yd1, yd2;
    always @(posedge clk) begin
        xd1 <= x;  xd2 <= xd1;
        yd1 <= y;  yd2 <= yd1;
    end
    assign colRunning = xd2[2:0];
    assign colMenu    = yd2[2:0];
    assign colPause   = xd2[2:0] ^ yd2[2:0];
    assign colOver    = ~xd2[2:0];

    function automatic int colorOf(logic [1:0] gs, int px, int py);
        case (gs)
            GAME_RUNNING: return px % 8;
            GAME_MENU:    return py % 8;
            GAME_PAUSE:   return (px ^ py) % 8;
            default:      return 7 - (px % 8);
        endcase
    endfunction

    typedef struct {
        int px;
        int py;
        int col;
        int cyc;
    } pix_t;

    pix_t expQ[$];
    int   frmQ[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   mActive = 0;
    bit   mPend = 0;
    int   mJ = 0;

    task automatic chk(string nm, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, got, exp, cyc);
        end
    endtask

    // Frame accepted at the edge numbered cyc.
    task automatic accept(logic [1:0] gs);
        pix_t p;
        mActive = 1;
        mJ = 0;
        mPend = 0;
        for (int k = 0; k < NPIX; k++) begin
            p.px  = k % W;
            p.py  = k / W;
            p.col = colorOf(gs, p.px, p.py);
            p.cyc = cyc + LAT + k;
            expQ.push_back(p);
        end
        frmQ.push_back(cyc + NPIX + LAT);
    endtask

    // Reference model: frame-level request bookkeeping.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!resetn) begin
                mActive = 0;
                mPend = 0;
                mJ = 0;
                expQ.delete();
                frmQ.delete();
            end else if (!mActive) begin
                if (start) accept(gameState);
            end else begin
                mJ++;
                if (mJ == DONEJ) begin
                    if (mPend || start) accept(gameState);
                    else mActive = 0;
                    mPend = 0;
                end else if (start) begin
                    mPend = 1;
                end
            end
        end
    end

    // Monitor: compare DUT outputs against queued expectations.
    initial begin
        pix_t e;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1) begin
                chk("busy", int'(busy), int'(mActive));
            end
            if (plot) begin
                if (expQ.size() == 0) begin
                    chk("unexpected plot", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    total++;
                    if (int'(plotX) != e.px || int'(plotY) != e.py ||
                        int'(plotColor) != e.col || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL pixel: got (%0d,%0d) col %0d cyc %0d expected (%0d,%0d) col %0d cyc %0d",
                                 plotX, plotY, plotColor, cyc,
                                 e.px, e.py, e.col, e.cyc);
                    end
                end
            end
            if (frameClk) begin
                if (frmQ.size() == 0) chk("unexpected frameClk", 1, 0);
                else chk("frameClk cycle", cyc, frmQ.pop_front());
            end
        end
    end

    task automatic checkReset();
        chk("rst x", int'(x), 0);
        chk("rst y", int'(y), 0);
        chk("rst plotX", int'(plotX), 0);
        chk("rst plotY", int'(plotY), 0);
        chk("rst plotColor", int'(plotColor), 0);
        chk("rst plot", int'(plot), 0);
        chk("rst frameClk", int'(frameClk), 0);
        chk("rst busy", int'(busy), 0);
    endtask

    task automatic pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitFrameClk();
        for (int i = 0; i < NPIX + 100; i++) begin
            @(negedge clk);
            if (frameClk) return;
        end
        chk("frameClk timeout", 0, 1);
    endtask

    task automatic waitPix(int target);
        for (int i = 0; i < NPIX + 100; i++) begin
            @(negedge clk);
            if (int'(y) * W + int'(x) >= target) return;
        end
        chk("pixel wait timeout", 0, 1);
    endtask

    initial begin
        resetn = 1'b0;
        start = 1'b1;
        gameState = GAME_RUNNING;
        repeat (3) @(negedge clk);
        checkReset();
        start = 1'b0;
        resetn = 1'b1;
        repeat (2 + $urandom_range(0, 4)) @(negedge clk);

        // Frame 1: RUNNING, live state wanders mid-frame.
        pulse();
        waitPix($urandom_range(2000, 8000));
        gameState = GAME_PAUSE;
        waitPix(10000 + $urandom_range(0, 5000));
        gameState = GAME_OVER;

        // Start in DONE: frame 2 (MENU) follows immediately.
        waitFrameClk();
        gameState = GAME_MENU;
        pulse();

        // Three requests in frame 2, state switched at pixel 5000.
        waitPix(1000 + $urandom_range(0, 2000));
        pulse();
        waitPix(5000);
        gameState = GAME_OVER;
        pulse();
        waitPix(12000 + $urandom_range(0, 5000));
        pulse();
        waitFrameClk();
        waitFrameClk();
        repeat (3 + $urandom_range(0, 4)) @(negedge clk);
        chk("idle busy", int'(busy), 0);

        // Reset at (80,60) aborts the frame.
        gameState = GAME_PAUSE;
        pulse();
        waitPix(60 * W + 80);
        chk("abort at x", int'(x), 80);
        chk("abort at y", int'(y), 60);
        resetn = 1'b0;
        @(negedge clk);
        checkReset();
        resetn = 1'b1;
        repeat (2 + $urandom_range(0, 4)) @(negedge clk);

        // Clean frame after the abort.
        gameState = 2'($urandom_range(0, 3));
        pulse();
        gameState = 2'($urandom_range(0, 3));
        waitFrameClk();
        repeat (5) @(negedge clk);
        chk("pixels left", expQ.size(), 0);
        chk("frames left", frmQ.size(), 0);
        chk("final busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
